// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data memory access unit: funct3 encodings, FSM codes, size helper.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mem_access_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // log2 of the access size in bytes; funct3[2] only carries signedness
  function automatic logic [1:0] size_of_funct3(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-cache strobe bundle for the memory access unit.
// Latency: none, wiring only.
// Backpressure: req_valid/req_ready toward the pipeline, mem_read/mem_write held until mem_resp.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_misaligned;
  logic                  resp_timeout;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_byte_enable;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;

  // unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_timeout,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  // pipeline + cache side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_timeout,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store shift + byte enables + legality/alignment, and load extract/extend.
// Latency: purely combinational.
// Backpressure: none.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [OFF_W-1:0]  req_off_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              misaligned_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [NB-1:0]     be_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  output logic [DATA_W-1:0] ld_data_o
);
  localparam int IW = $clog2(DATA_W);

  logic              legal;
  logic [1:0]        st_sz;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] bit_mask;
  logic [1:0]        ld_sz;
  logic [DATA_W-1:0] ld_sh;
  logic [IW-1:0]     sign_idx;
  logic              ext_bit;
  int                ld_bits;

  // Request side: decode legality, check alignment, build lane mask and shifted store data
  always_comb begin
    legal = 1'b0;
    if (req_we_i) begin
      case (req_funct3_i)
        SB, SH, SW: legal = 1'b1;
        SD:         legal = (DATA_W == 64);
        default:    legal = 1'b0;
      endcase
    end else begin
      case (req_funct3_i)
        LB, LH, LW, LBU, LHU: legal = 1'b1;
        LD, LWU:              legal = (DATA_W == 64);
        default:              legal = 1'b0;
      endcase
    end
    st_sz     = size_of_funct3(req_funct3_i);
    lane_mask = '0;
    for (int i = 0; i < NB; i++) lane_mask[i] = (i < (1 << st_sz));
    bit_mask = '0;
    for (int i = 0; i < DATA_W; i++) bit_mask[i] = lane_mask[i / 8];
    misaligned_o = !legal || (|(req_off_i & OFF_W'((32'd1 << st_sz) - 32'd1)));
    be_o         = lane_mask << req_off_i;
    wdata_o      = (req_wdata_i & bit_mask) << {req_off_i, 3'b000};
  end

  // Response side: bring the addressed bytes down to bit 0, then sign- or zero-extend
  always_comb begin
    ld_sz    = size_of_funct3(ld_funct3_i);
    ld_sh    = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_bits  = (8 << ld_sz) > DATA_W ? DATA_W : (8 << ld_sz);
    sign_idx = IW'(ld_bits - 1);
    ext_bit  = !ld_funct3_i[2] && ld_sh[sign_idx];
    ld_data_o = '0;
    for (int i = 0; i < DATA_W; i++) ld_data_o[i] = (i < ld_bits) ? ld_sh[i] : ext_bit;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, lane steering, cache handshake with watchdog, load extension.
// Latency: accept->resp_valid >= 2 cycles (misaligned: 1 cycle); abort after TIMEOUT BUSY cycles.
// Backpressure: req_ready only in IDLE; one access in flight, cache strobes held until mem_resp.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] BUSY = S_BUSY;
  localparam logic [1:0] DONE = S_DONE;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [OFF_W-1:0]  off_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [NB-1:0]     mem_be_q;
  logic              resp_valid_q, resp_mis_q, resp_to_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              al_mis;
  logic [DATA_W-1:0] al_wdata;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_ld_data;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .req_we_i     (bus.req_we),
    .req_funct3_i (bus.req_funct3),
    .req_off_i    (bus.req_addr[OFF_W-1:0]),
    .req_wdata_i  (bus.req_wdata),
    .misaligned_o (al_mis),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .ld_funct3_i  (funct3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (bus.mem_rdata),
    .ld_data_o    (al_ld_data)
  );

  // Next state; a response in the watchdog's final cycle still counts as a normal completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = al_mis ? DONE : BUSY;
      BUSY:    if (bus.mem_resp || cnt_d == CNT_W'(TIMEOUT)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, strobe hold, watchdog count and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_mis_q    <= 1'b0;
      resp_to_q     <= 1'b0;
      resp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            funct3_q      <= bus.req_funct3;
            off_q         <= bus.req_addr[OFF_W-1:0];
            mem_address_q <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (al_mis) begin
              resp_mis_q   <= 1'b1;
              resp_to_q    <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              mem_read_q  <= !bus.req_we;
              mem_write_q <= bus.req_we;
              mem_wdata_q <= bus.req_we ? al_wdata : '0;
              mem_be_q    <= al_be;
              cnt_q       <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_to_q    <= 1'b0;
            resp_rdata_q <= we_q ? '0 : al_ld_data;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_to_q    <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = resp_mis_q;
  assign bus.resp_timeout    = resp_to_q;
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;

endmodule
